// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory handshake and
// fills the IF/ID register, with a one-entry skid buffer and redirect drain.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [63:0] ID,
  output logic        ID_valid
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [31:0] RST_PC = RESET_PC & ~32'd3;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_addr;
  logic [31:0] w_pc, w_addr;
  logic [31:0] w_tgt, w_inc;
  logic [63:0] r_id, r_skid;
  logic [63:0] w_id, w_skid;
  logic        r_valid, w_valid;

  assign w_tgt = branch_target & ~32'd3;
  assign w_inc = r_pc + 32'd4;

  always_comb begin
    w_next  = r_state;
    w_pc    = r_pc;
    w_addr  = r_addr;
    w_id    = r_id;
    w_valid = r_valid;
    w_skid  = r_skid;
    unique case (r_state)
      FETCH: begin
        if (branch_taken) begin
          w_pc    = w_tgt;
          w_valid = 1'b0;
          w_skid  = '0;
          // A response still in flight must be drained before redirecting
          if (imem_ready) w_addr = w_tgt;
          else            w_next = DRAIN;
        end else if (imem_ready) begin
          w_pc   = w_inc;
          w_addr = w_inc;
          if (stall) begin
            w_skid = {r_pc, imem_rdata};
            w_next = HOLD;
          end else begin
            w_id    = {r_pc, imem_rdata};
            w_valid = 1'b1;
          end
        end else if (!stall) begin
          w_valid = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          w_pc    = w_tgt;
          w_addr  = w_tgt;
          w_valid = 1'b0;
          w_skid  = '0;
          w_next  = FETCH;
        end else if (!stall) begin
          w_id    = r_skid;
          w_valid = 1'b1;
          w_skid  = '0;
          w_next  = FETCH;
        end
      end
      DRAIN: begin
        w_valid = 1'b0;
        if (branch_taken) w_pc = w_tgt;
        if (imem_ready) begin
          w_addr = branch_taken ? w_tgt : r_pc;
          w_next = FETCH;
        end
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RST_PC;
      r_addr  <= RST_PC;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc;
      r_addr  <= w_addr;
      r_id    <= w_id;
      r_valid <= w_valid;
      r_skid  <= w_skid;
    end
  end

  assign imem_req  = ~reset & (r_state != HOLD);
  assign imem_addr = r_addr;
  assign ID        = r_id;
  assign ID_valid  = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic checked
// against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic        clock = 1'b0;
  logic        reset, stall, branch_taken, imem_ready;
  logic [31:0] branch_target, junk;
  logic        imem_req, ID_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [63:0] ID;
  logic        imem_req2, ID_valid2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic [63:0] ID2;

  always #5 clock = ~clock;

  // Memory answers whatever address is presented; garbage when not ready
  assign imem_rdata  = imem_ready ? (imem_addr ^ PAT) : junk;
  assign imem_rdata2 = imem_ready ? (imem_addr2 ^ PAT) : ~junk;

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .ID(ID), .ID_valid(ID_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_ready(imem_ready),
    .ID(ID2), .ID_valid(ID_valid2)
  );

  int errors = 0;
  int checks = 0;

  // Model: next fetch pc, presented address, IF/ID contents, parked
  // instructions, and whether the in-flight response is to be thrown away
  logic [31:0] m_pc, m_addr;
  logic [63:0] m_id;
  logic        m_valid, m_disc;
  logic [63:0] m_park[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic rdy);
    logic [31:0] t;
    logic [63:0] w;
    t = tgt & ~32'd3;
    if (rst) begin
      m_pc = 32'h0; m_addr = 32'h0; m_id = 64'h0;
      m_valid = 1'b0; m_disc = 1'b0; m_park.delete();
    end else if (m_park.size() != 0) begin
      if (br) begin
        m_pc = t; m_addr = t; m_valid = 1'b0; m_park.delete();
      end else if (!stl) begin
        m_id = m_park.pop_front(); m_valid = 1'b1;
      end
    end else if (m_disc) begin
      if (br) m_pc = t;
      if (rdy) begin m_addr = m_pc; m_disc = 1'b0; end
    end else if (br) begin
      m_pc = t; m_valid = 1'b0;
      if (rdy) m_addr = t; else m_disc = 1'b1;
    end else if (rdy) begin
      w = {m_addr, m_addr ^ PAT};
      m_addr = m_addr + 32'd4;
      m_pc = m_addr;
      if (stl) m_park.push_back(w);
      else begin m_id = w; m_valid = 1'b1; end
    end else if (!stl) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic rst, input logic stl, input logic br,
                     input logic [31:0] tgt, input logic rdy);
    reset = rst; stall = stl; branch_taken = br;
    branch_target = tgt; imem_ready = rdy; junk = $urandom;
    #1;
    chk("req", 64'(imem_req), 64'(!rst && m_park.size() == 0));
    chk("addr", 64'(imem_addr), 64'(m_addr));
    chk("valid", 64'(ID_valid), 64'(m_valid));
    if (m_valid) chk("id", ID, m_id);
    @(posedge clock);
    model(rst, stl, br, tgt, rdy);
    #1;
  endtask

  initial begin
    logic [31:0] t;
    logic        r, s, b, y;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_ready = 1'b1; junk = $urandom;
    repeat (2) @(posedge clock);
    #1;
    model(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_id", ID, 64'h0);
    chk("rst_valid", 64'(ID_valid), 64'h0);
    chk("rst_req", 64'(imem_req), 64'h0);
    chk("rst_addr", 64'(imem_addr), 64'h0);
    chk("rst_addr2", 64'(imem_addr2), 64'hFFFF_FFF8);

    // Zero-wait streaming; second instance checks wrap near 2^32
    cyc(0, 0, 0, 0, 1);
    chk("wrap_id0", ID2, {32'hFFFF_FFF8, 32'hFFFF_FFF8 ^ PAT});
    cyc(0, 0, 0, 0, 1);
    chk("wrap_id1", ID2, {32'hFFFF_FFFC, 32'hFFFF_FFFC ^ PAT});
    cyc(0, 0, 0, 0, 1);
    chk("wrap_id2", ID2, {32'h0000_0000, 32'h0000_0000 ^ PAT});
    chk("wrap_valid", 64'(ID_valid2), 64'h1);
    cyc(0, 0, 0, 0, 1);

    // Wait states at address 8
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Stall while the response for 4 arrives
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Redirect to 0x103 with the fetch of 12 outstanding
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h103, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("redir_addr", 64'(imem_addr), 64'h100);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Redirect together with stall while parked
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 32'h40, 0);
    chk("hold_br_addr", 64'(imem_addr), 64'h40);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Second redirect during drain wins
    cyc(0, 0, 1, 32'h200, 0);
    cyc(0, 0, 1, 32'h301, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h500, 0);
    cyc(0, 0, 1, 32'h600, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Random traffic, with targets biased toward the top of memory
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom % 100) == 0;
      s = ($urandom % 4) == 0;
      b = ($urandom % 12) == 0;
      y = ($urandom % 10) < 7;
      t = ($urandom % 3 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      cyc(r, s, b, t, y);
    end
    cyc(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
